// File: rtl/instr_issue_if.sv
// ---------------------------------------------------------------------------
// instr_issue_if
//   Groups the signals between the instruction-issue block and the rest of
//   the core: the run/step controls, the instruction memory port, the
//   strobes from the control FSM, and the decoded outputs sent back to it.
//
//   Modports
//     master : the control FSM, instruction memory and front panel side
//              (drives run, step, imem_data, ir_load, pc_load, pc_target,
//              flags_load, alu_flags, fsm_at_if)
//     slave  : instr_issue itself (drives pc_out, opcode_out, imm_out,
//              flags_out, cycle_en)
// ---------------------------------------------------------------------------
interface instr_issue_if;
    logic        run;         // level: free-running execution
    logic        step;        // single-step request pulse
    logic [15:0] imem_data;   // instruction word at pc_out
    logic        ir_load;     // IF state: latch IR, advance PC
    logic        pc_load;     // WbPC state: load pc_target
    logic [5:0]  pc_target;   // branch/jump address
    logic        flags_load;  // capture alu_flags
    logic [3:0]  alu_flags;   // {carry, overflow, negative, zero}
    logic        fsm_at_if;   // control FSM currently in IF
    logic [5:0]  pc_out;      // instruction memory address
    logic [26:0] opcode_out;  // {RX, RY, one-hot instruction[22:0]}
    logic [7:0]  imm_out;     // IR[7:0]
    logic [3:0]  flags_out;   // registered flags
    logic        cycle_en;    // clock-enable for control FSM and datapath

    modport master (
        output run, step, imem_data, ir_load, pc_load, pc_target,
               flags_load, alu_flags, fsm_at_if,
        input  pc_out, opcode_out, imm_out, flags_out, cycle_en
    );

    modport slave (
        input  run, step, imem_data, ir_load, pc_load, pc_target,
               flags_load, alu_flags, fsm_at_if,
        output pc_out, opcode_out, imm_out, flags_out, cycle_en
    );
endinterface

// File: rtl/instr_issue.sv
// ---------------------------------------------------------------------------
// instr_issue
//   Program counter, instruction register, flag register, one-hot decoder
//   and run/step controller for a small 16-bit core.
//
//   IR format: op=IR[15:12], RX=IR[11:10], RY=IR[9:8], imm=IR[7:0].
//   opcode_out = {RX, RY, onehot[22:0]}, decoded combinationally from IR.
//
//   Ports
//     clock : system clock, all state updates on the rising edge
//     reset : synchronous active-high reset
//     bus   : instr_issue_if.slave (see interface file for signal list)
//
//   Configuration
//     INSTR_ISSUE_STEP_EN : when defined, the step input is honoured and the
//       run controller gains STEP_FETCH/STEP_EXEC states. When undefined,
//       step is ignored and only STOPPED/RUNNING exist.
// ---------------------------------------------------------------------------
module instr_issue (
    input  logic         clock,
    input  logic         reset,
    instr_issue_if.slave bus
);

`ifdef INSTR_ISSUE_STEP_EN
    typedef enum logic [1:0] {STOPPED, RUNNING, STEP_FETCH, STEP_EXEC} run_state_t;
`else
    typedef enum logic [0:0] {STOPPED, RUNNING} run_state_t;
`endif

    run_state_t  state, state_next;
    logic [5:0]  pc;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic [22:0] onehot;
    logic        cycle_en;

    // ------------------------------------------------------------------
    // Clock enable. In STEP_EXEC the enable drops on the very cycle the
    // control FSM reaches IF, so the following fetch never happens.
    // ------------------------------------------------------------------
    always_comb begin
        cycle_en = (state != STOPPED);
`ifdef INSTR_ISSUE_STEP_EN
        if (state == STEP_EXEC && bus.fsm_at_if)
            cycle_en = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Run controller: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        state_next = state;
        case (state)
            STOPPED: begin
                if (bus.run)
                    state_next = RUNNING;
`ifdef INSTR_ISSUE_STEP_EN
                else if (bus.step)
                    state_next = STEP_FETCH;
`endif
            end
            // Stop only at an instruction boundary.
            RUNNING:
                if (!bus.run && bus.fsm_at_if)
                    state_next = STOPPED;
`ifdef INSTR_ISSUE_STEP_EN
            STEP_FETCH:
                if (bus.ir_load)
                    state_next = STEP_EXEC;
            STEP_EXEC:
                if (bus.fsm_at_if)
                    state_next = STOPPED;
`endif
            default: state_next = STOPPED;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset)
            state <= STOPPED;
        else
            state <= state_next;
    end

    // ------------------------------------------------------------------
    // PC / IR / flags. pc_load wins the PC when it coincides with ir_load;
    // the IR still latches. The 6-bit increment wraps 63 -> 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
        end else if (cycle_en) begin
            if (bus.ir_load)
                ir <= bus.imem_data;
            if (bus.pc_load)
                pc <= bus.pc_target;
            else if (bus.ir_load)
                pc <= pc + 6'd1;
            if (bus.flags_load)
                flags <= bus.alu_flags;
        end
    end

    // ------------------------------------------------------------------
    // One-hot decode of the registered IR
    // ------------------------------------------------------------------
    always_comb begin
        onehot = '0;
        case (ir[15:12])
            4'h0: onehot[0]  = 1'b1;                         // NOOP
            4'h1: onehot[5'd1 + 5'(ir[9:8])] = 1'b1;         // INPUTC/CF/D/DF
            4'h2: onehot[5]  = 1'b1;                         // MOVE
            4'h3: onehot[6]  = 1'b1;                         // LOADI/LOADP
            4'h4: onehot[7]  = 1'b1;                         // ADD
            4'h5: onehot[8]  = 1'b1;                         // ADDI
            4'h6: onehot[9]  = 1'b1;                         // SUB
            4'h7: onehot[10] = 1'b1;                         // SUBI
            4'h8: onehot[11] = 1'b1;                         // LOAD
            4'h9: onehot[12] = 1'b1;                         // LOADF
            4'hA: onehot[13] = 1'b1;                         // STORE
            4'hB: onehot[14] = 1'b1;                         // STOREF
            4'hC: onehot[ir[8] ? 5'd16 : 5'd15] = 1'b1;      // SHIFTR / SHIFTL
            4'hD: onehot[17] = 1'b1;                         // CMP
            4'hE: onehot[18] = 1'b1;                         // JUMP
            4'hF: onehot[5'd19 + 5'(ir[9:8])] = 1'b1;        // BRE/BRNE/BRG/BRGE
            default: onehot = '0;
        endcase
    end

    assign bus.pc_out     = pc;
    assign bus.opcode_out = {ir[11:8], onehot};
    assign bus.imm_out    = ir[7:0];
    assign bus.flags_out  = flags;
    assign bus.cycle_en   = cycle_en;

endmodule
